// File: rtl/sine_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sine_sequencer
// Purpose  : Phase-accumulator address generator and registered sample capture
//            for a 512-entry sine memory. Define SINE_SEQ_ATTEN_EN to add a
//            2-bit arithmetic attenuation applied around mid-scale.
// Revision : 1.0
// ============================================================================
module sine_sequencer #(
    parameter int CLK_DIV   = 12,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 phase_reset,
    input  logic [ACC_WIDTH-1:0] tuning_word,
`ifdef SINE_SEQ_ATTEN_EN
    input  logic [1:0]           atten,
`endif
    input  logic [9:0]           read_data,
    output logic [8:0]           read_address,
    output logic [9:0]           sample,
    output logic                 sample_valid
);

    localparam int                 C_DIV_W    = $clog2(CLK_DIV);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]         C_MIDSCALE = 10'd512;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_FETCH   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_DIV_W-1:0]   div_q, div_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [8:0]           read_address_q, read_address_d;
    logic [9:0]           sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 tick;
    logic [9:0]           capture_value;

    assign tick = enable && (div_q == C_DIV_LAST);

`ifdef SINE_SEQ_ATTEN_EN
    logic [1:0]         atten_q, atten_d;
    logic signed [10:0] centered;
    logic signed [10:0] scaled;

    // Attenuation is applied to the signed offset from mid-scale, so the
    // result always stays inside the 10-bit offset-binary range.
    always_comb begin
        atten_d       = (tick && !phase_reset) ? atten : atten_q;
        centered      = $signed({1'b0, read_data}) - 11'sd512;
        scaled        = centered >>> atten_q;
        capture_value = 10'(scaled + 11'sd512);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            atten_q <= 2'd0;
        end else begin
            atten_q <= atten_d;
        end
    end
`else
    assign capture_value = read_data;
`endif

    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        acc_d          = acc_q;
        read_address_d = read_address_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;

        if (enable) begin
            div_d = tick ? '0 : div_q + C_DIV_W'(1);
        end
        if (tick) begin
            acc_d          = acc_q + tuning_word;
            read_address_d = acc_d[ACC_WIDTH-1 -: 9];
        end

        case (state_q)
            S_IDLE: begin
                // A held divider can tick in the very first enabled cycle.
                if (tick)        state_d = S_FETCH;
                else if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick)         state_d = S_FETCH;
                else if (!enable) state_d = S_IDLE;
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                sample_d       = capture_value;
                sample_valid_d = 1'b1;
                if (tick)        state_d = S_FETCH;
                else if (enable) state_d = S_WAIT;
                else             state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (phase_reset) begin
            acc_d          = '0;
            read_address_d = '0;
            div_d          = '0;
            sample_d       = sample_q;
            sample_valid_d = 1'b0;
            state_d        = enable ? S_WAIT : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            div_q          <= '0;
            acc_q          <= '0;
            read_address_q <= '0;
            sample_q       <= C_MIDSCALE;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            acc_q          <= acc_d;
            read_address_q <= read_address_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign read_address = read_address_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule
`default_nettype wire
